// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: FSM states, parity modes,
// and the legal parameter ranges.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAR,
        STOP,
        BREAK_WAIT
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int DATA_BITS_MIN  = 5;
    localparam int DATA_BITS_MAX  = 9;
    localparam int STOP_BITS_MIN  = 1;
    localparam int STOP_BITS_MAX  = 2;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 64;

    function automatic bit cfg_legal(input int db, input int pm, input int sb,
                                     input int fd, input int thr);
        return (db >= DATA_BITS_MIN) && (db <= DATA_BITS_MAX) &&
               (pm == PAR_NONE || pm == PAR_ODD || pm == PAR_EVEN) &&
               (sb >= STOP_BITS_MIN) && (sb <= STOP_BITS_MAX) &&
               (fd >= FIFO_DEPTH_MIN) && (fd <= FIFO_DEPTH_MAX) &&
               ((fd & (fd - 1)) == 0) && (thr >= 0) && (thr <= fd);
    endfunction

    // ones_odd is the XOR of the data bits together with the received parity bit.
    function automatic logic parity_bad(input int mode, input logic ones_odd);
        if (mode == PAR_ODD)
            return ~ones_odd;
        else if (mode == PAR_EVEN)
            return ones_odd;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle, and a pop of an empty FIFO is ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Head is forced to zero while empty so nothing stale is ever presented.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)
                count_q <= count_q + CW'(1);
            else if (do_pop && !do_push)
                count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver sampling rx once per baud_clk edge, with a receive FIFO,
// registered RTS flow control and sticky error flags.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int RTS_THRESH = FIFO_DEPTH - 2
) (
    input  logic                            baud_clk,
    input  logic                            rst,
    input  logic                            rx,
    input  logic                            rd_en,
    input  logic                            clr_err,
    output logic [DATA_BITS-1:0]            data_out,
    output logic                            data_valid,
    output logic                            rx_buffer_empty,
    output logic                            rts,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun
);

    localparam int             CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0]  THRESH    = CW'(RTS_THRESH);
    localparam bit             CFG_OK    = cfg_legal(DATA_BITS, PARITY, STOP_BITS,
                                                     FIFO_DEPTH, RTS_THRESH);

    uart_state_e          state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frame_err_q, parity_err_q, overrun_q, rts_q;
    logic                 frame_ok, set_frame_err, set_parity_err;

    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_cnt, cnt_next;
    logic                 pop_ok, push_ok, set_overrun;

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        par_bad_d      = par_bad_q;
        frame_ok       = 1'b0;
        set_frame_err  = 1'b0;
        set_parity_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            DATA: begin
                shift_d = {rx, shift_q[DATA_BITS-1:1]};
                if (bit_cnt_q == LAST_DATA) begin
                    bit_cnt_d = '0;
                    state_d   = (PARITY != PAR_NONE) ? PAR : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            PAR: begin
                par_bad_d = parity_bad(PARITY, ^{shift_q, rx});
                state_d   = STOP;
            end
            STOP: begin
                if (!rx) begin
                    set_frame_err = 1'b1;
                    bit_cnt_d     = '0;
                    state_d       = BREAK_WAIT;
                end else if (bit_cnt_q == LAST_STOP) begin
                    bit_cnt_d      = '0;
                    state_d        = IDLE;
                    set_parity_err = par_bad_q;
                    frame_ok       = ~par_bad_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            BREAK_WAIT: begin
                if (rx)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts the frame when the same edge pops the head.
    assign pop_ok      = rd_en & ~fifo_empty;
    assign push_ok     = frame_ok & (~fifo_full | pop_ok);
    assign set_overrun = frame_ok & fifo_full & ~rd_en;

    always_comb begin
        cnt_next = fifo_cnt;
        if (push_ok && !pop_ok)
            cnt_next = fifo_cnt + CW'(1);
        else if (pop_ok && !push_ok)
            cnt_next = fifo_cnt - CW'(1);
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (baud_clk),
        .rst_i   (rst),
        .push_i  (push_ok),
        .data_i  (shift_q),
        .pop_i   (pop_ok),
        .data_o  (data_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            rts_q        <= 1'b1;
        end else begin
            frame_err_q  <= set_frame_err  | (frame_err_q  & ~clr_err);
            parity_err_q <= set_parity_err | (parity_err_q & ~clr_err);
            overrun_q    <= set_overrun    | (overrun_q    & ~clr_err);
            rts_q        <= (cnt_next < THRESH);
        end
    end

    cfg_legal_a: assert property (@(posedge baud_clk) CFG_OK);

    assign data_valid      = ~fifo_empty;
    assign rx_buffer_empty = fifo_empty;
    assign fifo_count      = fifo_cnt;
    assign rts             = rts_q;
    assign frame_err       = frame_err_q;
    assign parity_err      = parity_err_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench: three receiver instances (8N1, 8E1, 8N1 with a 4-deep FIFO)
// driven from one linear sequence against hand-computed expectations.
module tb_uart_rx_buffered;

    logic       clk = 1'b0;
    logic       rx0, rd0, clr0, rst0;
    logic       rx1, rd1, clr1, rst1;
    logic       rx2, rd2, clr2, rst2;
    logic [7:0] dout0, dout1, dout2;
    logic       dv0, dv1, dv2, emp0, emp1, emp2, rts0, rts1, rts2;
    logic [3:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic       fe0, pe0, ov0, fe1, pe1, ov1, fe2, pe2, ov2;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_rx_buffered u0 (
        .baud_clk(clk), .rst(rst0), .rx(rx0), .rd_en(rd0), .clr_err(clr0),
        .data_out(dout0), .data_valid(dv0), .rx_buffer_empty(emp0), .rts(rts0),
        .fifo_count(cnt0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_buffered #(.PARITY(2)) u1 (
        .baud_clk(clk), .rst(rst1), .rx(rx1), .rd_en(rd1), .clr_err(clr1),
        .data_out(dout1), .data_valid(dv1), .rx_buffer_empty(emp1), .rts(rts1),
        .fifo_count(cnt1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    uart_rx_buffered #(.FIFO_DEPTH(4), .RTS_THRESH(2)) u2 (
        .baud_clk(clk), .rst(rst2), .rx(rx2), .rd_en(rd2), .clr_err(clr2),
        .data_out(dout2), .data_valid(dv2), .rx_buffer_empty(emp2), .rts(rts2),
        .fifo_count(cnt2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit on the selected instance's rx, then step past one sampling edge.
    task automatic bitx(input int d, input logic b);
        case (d)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit; stop bit left to caller.
    task automatic frame(input int d, input logic [7:0] v, input int pmode, input logic pflip);
        logic pb;
        bitx(d, 1'b0);
        for (int i = 0; i < 8; i++)
            bitx(d, v[i]);
        if (pmode != 0) begin
            pb = (pmode == 1) ? ~(^v) : ^v;
            bitx(d, pb ^ pflip);
        end
    endtask

    initial begin
        int         sa [10];
        logic [7:0] drain_exp [4];
        logic [2:0] drain_cnt [4];
        logic       drain_rts [4];
        logic [7:0] v;

        sa = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        drain_exp = '{8'h22, 8'h33, 8'h44, 8'h66};
        drain_cnt = '{3'd3, 3'd2, 3'd1, 3'd0};
        drain_rts = '{1'b0, 1'b0, 1'b1, 1'b1};

        {rx0, rx1, rx2}    = 3'b111;
        {rd0, rd1, rd2}    = 3'b000;
        {clr0, clr1, clr2} = 3'b000;
        {rst0, rst1, rst2} = 3'b111;
        repeat (2) @(posedge clk);
        #1;

        chk("reset_valid", {31'd0, dv0}, 32'd0);
        chk("reset_empty", {31'd0, emp0}, 32'd1);
        chk("reset_rts", {31'd0, rts0}, 32'd1);
        chk("reset_count", {28'd0, cnt0}, 32'd0);
        chk("reset_errs", {29'd0, fe0, pe0, ov0}, 32'd0);
        chk("reset_dout", {24'd0, dout0}, 32'd0);
        chk("reset_rts_u2", {31'd0, rts2}, 32'd1);

        {rst0, rst1, rst2} = 3'b000;
        bitx(0, 1'b1);
        bitx(0, 1'b1);

        // 8N1 frame 0xA5 from the raw sample list
        for (int i = 0; i < 9; i++)
            bitx(0, sa[i][0]);
        chk("a5_before_stop_count", {28'd0, cnt0}, 32'd0);
        bitx(0, sa[9][0]);
        chk("a5_valid", {31'd0, dv0}, 32'd1);
        chk("a5_empty", {31'd0, emp0}, 32'd0);
        chk("a5_dout", {24'd0, dout0}, 32'h0000_00A5);
        chk("a5_count", {28'd0, cnt0}, 32'd1);
        chk("a5_errs", {29'd0, fe0, pe0, ov0}, 32'd0);
        chk("a5_rts", {31'd0, rts0}, 32'd1);

        rd0 = 1'b1;
        bitx(0, 1'b1);
        rd0 = 1'b0;
        chk("pop_count", {28'd0, cnt0}, 32'd0);
        chk("pop_empty", {31'd0, emp0}, 32'd1);
        chk("pop_dout", {24'd0, dout0}, 32'd0);

        rd0 = 1'b1;
        bitx(0, 1'b1);
        rd0 = 1'b0;
        chk("pop_when_empty_count", {28'd0, cnt0}, 32'd0);
        chk("pop_when_empty_valid", {31'd0, dv0}, 32'd0);

        // Stop sample low, line held low 5 edges, then 0x3C
        frame(0, 8'hFF, 0, 1'b0);
        bitx(0, 1'b0);
        chk("break_frame_err", {31'd0, fe0}, 32'd1);
        chk("break_count", {28'd0, cnt0}, 32'd0);
        repeat (4) bitx(0, 1'b0);
        bitx(0, 1'b1);
        chk("break_no_push", {28'd0, cnt0}, 32'd0);
        frame(0, 8'h3C, 0, 1'b0);
        bitx(0, 1'b1);
        chk("after_break_count", {28'd0, cnt0}, 32'd1);
        chk("after_break_dout", {24'd0, dout0}, 32'h0000_003C);
        chk("frame_err_sticky", {31'd0, fe0}, 32'd1);
        clr0 = 1'b1;
        bitx(0, 1'b1);
        clr0 = 1'b0;
        chk("frame_err_cleared", {31'd0, fe0}, 32'd0);

        // Reset at the 4th data bit, then a clean 0x55 starting on the first edge
        bitx(0, 1'b0);
        bitx(0, 1'b1);
        bitx(0, 1'b0);
        bitx(0, 1'b1);
        rst0 = 1'b1;
        rx0  = 1'b0;
        #1;
        chk("async_reset_count", {28'd0, cnt0}, 32'd0);
        chk("async_reset_valid", {31'd0, dv0}, 32'd0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        frame(0, 8'h55, 0, 1'b0);
        bitx(0, 1'b1);
        chk("post_reset_count", {28'd0, cnt0}, 32'd1);
        chk("post_reset_dout", {24'd0, dout0}, 32'h0000_0055);
        chk("post_reset_errs", {29'd0, fe0, pe0, ov0}, 32'd0);

        // Even parity: 0x0F with parity 1 is bad, with parity 0 is good
        frame(1, 8'h0F, 2, 1'b1);
        bitx(1, 1'b1);
        chk("par_err_set", {31'd0, pe1}, 32'd1);
        chk("par_err_no_push", {31'd0, emp1}, 32'd1);
        chk("par_err_no_fe", {31'd0, fe1}, 32'd0);
        clr1 = 1'b1;
        bitx(1, 1'b1);
        clr1 = 1'b0;
        chk("par_err_cleared", {31'd0, pe1}, 32'd0);
        frame(1, 8'h0F, 2, 1'b0);
        bitx(1, 1'b1);
        chk("par_good_count", {28'd0, cnt1}, 32'd1);
        chk("par_good_dout", {24'd0, dout1}, 32'h0000_000F);
        frame(1, 8'h07, 2, 1'b0);
        bitx(1, 1'b1);
        chk("par_good2_count", {28'd0, cnt1}, 32'd2);
        chk("par_good2_err", {31'd0, pe1}, 32'd0);

        // Depth 4, threshold 2: five frames, no reads
        for (int k = 1; k <= 5; k++) begin
            v = 8'(8'h11 * k);
            frame(2, v, 0, 1'b0);
            bitx(2, 1'b1);
            if (k == 1) begin
                chk("fill1_count", {29'd0, cnt2}, 32'd1);
                chk("fill1_rts", {31'd0, rts2}, 32'd1);
            end else if (k == 2) begin
                chk("fill2_count", {29'd0, cnt2}, 32'd2);
                chk("fill2_rts", {31'd0, rts2}, 32'd0);
            end else if (k == 4) begin
                chk("fill4_count", {29'd0, cnt2}, 32'd4);
                chk("fill4_overrun", {31'd0, ov2}, 32'd0);
            end else if (k == 5) begin
                chk("fill5_overrun", {31'd0, ov2}, 32'd1);
                chk("fill5_count", {29'd0, cnt2}, 32'd4);
                chk("fill5_dout", {24'd0, dout2}, 32'h0000_0011);
            end
        end

        // Overrun and clear on the same edge: set wins
        frame(2, 8'h77, 0, 1'b0);
        clr2 = 1'b1;
        bitx(2, 1'b1);
        clr2 = 1'b0;
        chk("set_wins_overrun", {31'd0, ov2}, 32'd1);
        chk("set_wins_count", {29'd0, cnt2}, 32'd4);
        clr2 = 1'b1;
        bitx(2, 1'b1);
        clr2 = 1'b0;
        chk("overrun_cleared", {31'd0, ov2}, 32'd0);

        // Full FIFO, completion edge coincident with a read
        frame(2, 8'h66, 0, 1'b0);
        rd2 = 1'b1;
        bitx(2, 1'b1);
        rd2 = 1'b0;
        chk("full_rd_overrun", {31'd0, ov2}, 32'd0);
        chk("full_rd_count", {29'd0, cnt2}, 32'd4);
        chk("full_rd_dout", {24'd0, dout2}, 32'h0000_0022);

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_dout", i), {24'd0, dout2}, {24'd0, drain_exp[i]});
            rd2 = 1'b1;
            bitx(2, 1'b1);
            rd2 = 1'b0;
            chk($sformatf("drain%0d_count", i), {29'd0, cnt2}, {29'd0, drain_cnt[i]});
            chk($sformatf("drain%0d_rts", i), {31'd0, rts2}, {31'd0, drain_rts[i]});
        end
        chk("drained_empty", {31'd0, emp2}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..9).
REQ-002 Parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-003 Parameter STOP_BITS, default 1, meaning stop bits checked per frame (legal 1..2).
REQ-004 Parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of 2, 2..64).
REQ-005 Parameter RTS_THRESH, default FIFO_DEPTH-2, meaning fill level at which rts deasserts.
REQ-006 Port baud_clk, input, 1, meaning bit clock: one rising edge per bit period, one rx sample per edge.
REQ-007 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-008 Port rx, input, 1, meaning serial line, idle high, pre-synchronised.
REQ-009 Port rd_en, input, 1, meaning pop FIFO head this cycle.
REQ-010 Port clr_err, input, 1, meaning clear all sticky error flags.
REQ-011 Port data_out, output, DATA_BITS, meaning FIFO head word (show-ahead).
REQ-012 Port data_valid, output, 1, meaning FIFO not empty; data_out valid.
REQ-013 Port rx_buffer_empty, output, 1, meaning FIFO empty (equals ~data_valid).
REQ-014 Port rts, output, 1, meaning 1 = ready to receive, 0 = stop sending.
REQ-015 Port fifo_count, output, $clog2(FIFO_DEPTH+1), meaning current FIFO occupancy.
REQ-016 Port frame_err, parity_err, overrun, output, 1 each, meaning sticky error flags.

Function
REQ-017 FSM states: IDLE, DATA, PAR, STOP, BREAK_WAIT; one transition decision per baud_clk edge.
REQ-018 IDLE: the edge sampling rx=0 counts as the start-bit sample; next state DATA, bit counter cleared.
REQ-019 DATA: shift in DATA_BITS samples LSB first, one per edge; then PAR if PARITY!=0, else STOP.
REQ-020 PAR: one sample; odd mode requires data bits plus parity bit to hold an odd number of 1s, even mode an even number.
REQ-021 STOP: STOP_BITS samples; every stop sample must be 1, otherwise frame error.
REQ-022 Frame completes at the edge sampling the last stop bit, which is edge DATA_BITS+(PARITY!=0)+STOP_BITS after the start edge; FSM returns to IDLE at that edge.
REQ-023 Good frame: push to FIFO at the completion edge; data_valid/fifo_count reflect the push after that edge (latency 0 cycles after completion edge).
REQ-024 Parity error: frame dropped, parity_err set; FSM returns to IDLE.
REQ-025 Stop-bit error: frame dropped, frame_err set; if the failing sample is 0, FSM enters BREAK_WAIT and remains there until rx samples 1, then IDLE; no start detection in BREAK_WAIT.
REQ-026 Good frame while FIFO full and rd_en=0: frame dropped, overrun set, FIFO unchanged.
REQ-027 Good frame while FIFO full and rd_en=1 in the same cycle: pop and push both occur; no overrun; count unchanged.
REQ-028 rd_en while empty: ignored; no pointer or count change.
REQ-029 Pointers wrap modulo FIFO_DEPTH; count saturates at neither end, being bounded by REQ-026 and REQ-028.
REQ-030 rts registered: 0 when post-edge count >= RTS_THRESH, 1 otherwise.
REQ-031 Error flags sticky until clr_err=1; set and clear in the same cycle means set wins.

Reset
REQ-032 rst asserted: FSM=IDLE, bit counter=0, shift register=0, FIFO pointers/count=0, data_valid=0, rx_buffer_empty=1, rts=1, all error flags=0, data_out=0.
REQ-033 rst mid-frame: partial frame discarded; the first edge after release samples as IDLE.

Structure
REQ-034 Package uart_pkg holds the FSM state enum, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), and the parameter legality limits.
REQ-035 The FIFO is a sub-module, uart_sync_fifo, parametrised in width and depth, with push, pop, full, empty and count.

Verification
REQ-036 Defaults (8N1), rx = 0,1,0,1,0,0,1,0,1,1 -> after the 10th edge data_valid=1, data_out=0xA5, fifo_count=1, no errors.
REQ-037 PARITY=2, frame 0x0F with parity bit 1 -> parity_err=1, FIFO empty; clr_err pulse -> parity_err=0.
REQ-038 8N1, stop sample 0 with rx held low 5 edges, then high -> frame_err=1, no push, no start detected until rx=1, next 0x3C frame received correctly.
REQ-039 FIFO_DEPTH=4, RTS_THRESH=2, 5 frames with no reads -> rts=0 after the 2nd frame, overrun=1 on the 5th, data_out=1st frame.
REQ-040 Full FIFO, 5th frame completion edge coincident with rd_en=1 -> no overrun, count stays 4, head advances to 2nd frame.
REQ-041 rst asserted at the 4th data bit, then a clean 0x55 frame -> only 0x55 in FIFO, count=1.
